// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller.
// Holds the FSM states, opcodes, functs, ALU operation codes and the aluop field.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQEX   = 4'd8,
        S_BGTZEX  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_IMMEX   = 4'd11,
        S_IMMWB   = 4'd12,
        S_JUMP    = 4'd13
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_OP    = 2'b11
    } aluop_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LI    = 6'b110000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SRLV = 6'b000110;

    // Bit 4 inverts B and sets carry-in; bits [3:0] select the operation.
    localparam logic [4:0] ALU_AND  = 5'b00000;
    localparam logic [4:0] ALU_OR   = 5'b00001;
    localparam logic [4:0] ALU_ADD  = 5'b00010;
    localparam logic [4:0] ALU_SUB  = 5'b10010;
    localparam logic [4:0] ALU_SLT  = 5'b10011;
    localparam logic [4:0] ALU_XORI = 5'b00100;
    localparam logic [4:0] ALU_LUI  = 5'b00101;
    localparam logic [4:0] ALU_SRLV = 5'b00110;
    localparam logic [4:0] ALU_LI   = 5'b00111;
    localparam logic [4:0] ALU_BGTZ = 5'b01000;

endpackage

// File: rtl/mc_aludec.sv
// Combinational ALU decoder: aluop selects a fixed ADD/SUB, the R-type funct
// field, or the immediate/branch opcode as the source of the ALU operation.
module mc_aludec
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [4:0] alucontrol
);

    always_comb begin
        // NOTE: the default is assigned first so every path drives alucontrol and no latch is inferred.
        alucontrol = ALU_ADD;
        unique case (aluop_e'(aluop))
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    FN_SRLV: alucontrol = ALU_SRLV;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            ALUOP_OP: begin
                case (op)
                    OP_XORI: alucontrol = ALU_XORI;
                    OP_LUI:  alucontrol = ALU_LUI;
                    OP_LI:   alucontrol = ALU_LI;
                    OP_BGTZ: alucontrol = ALU_BGTZ;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing the datapath plus ALU decoder.
// Synchronous active-low reset; write enables are masked combinationally while in reset.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] pcsrc,
    output logic [4:0] alucontrol,
    output logic [3:0] state
);

    state_e     state_q;
    state_e     state_d;
    state_e     dec_state;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // While reset is held, outputs decode as FETCH regardless of the register contents.
    assign dec_state = reset_n ? state_q : S_FETCH;

    always_comb begin
        state_d  = S_FETCH;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        pcsrc    = 2'b00;
        aluop    = ALUOP_ADD;

        case (dec_state)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW:           state_d = S_MEMADR;
                    OP_RTYPE:               state_d = S_EXECUTE;
                    OP_BEQ:                 state_d = S_BEQEX;
                    OP_BGTZ:                state_d = S_BGTZEX;
                    OP_ADDI:                state_d = S_ADDIEX;
                    OP_XORI, OP_LUI, OP_LI: state_d = S_IMMEX;
                    OP_J:                   state_d = S_JUMP;
                    default:                state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            // The ALU reports zero when A > 0 signed, so zero selects the taken path.
            S_BGTZEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_OP;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_IMMWB;
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = ALUOP_OP;
                state_d = S_IMMWB;
            end
            S_IMMWB: begin
                regwrite = 1'b1;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        if (!reset_n) begin
            pcwrite  = 1'b0;
            branch   = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
        end
    end

    assign pcen  = pcwrite | (branch & zero);
    assign state = state_q;

    mc_aludec u_aludec (
        .aluop      (aluop),
        .op         (op),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle MIPS control unit: the producer side of the ALU's 5-bit alucontrol interface, and the consumer of its zero flag.
- A Moore FSM sequences fetch/decode/execute/writeback for the datapath.
- A combinational ALU decoder maps aluop+funct onto the ALU's operation codes.
- Sits between the instruction register (op, funct) and the multicycle datapath muxes/enables.

Parameters:
- none (encodings fixed in the shared package)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag, sampled in branch states
- pcen  out  1  PC write enable = pcwrite | (branch & zero)
- memwrite  out  1  data memory write
- irwrite  out  1  instruction register load
- regwrite  out  1  register file write
- alusrca  out  1  0 = PC, 1 = A register
- alusrcb  out  2  00 = B, 01 = const 4, 10 = signimm, 11 = signimm<<2
- iord  out  1  0 = PC addresses memory, 1 = ALUOut
- memtoreg  out  1  1 = write data register to the register file
- regdst  out  1  1 = rd, 0 = rt
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  5  bit4 = invert B and carry-in; [3:0] = op select
- state  out  4  current state, for debug/verification

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous, active-low.
  - reset_n==0 at a rising edge loads state FETCH.
  - While reset_n==0, pcen, irwrite, regwrite and memwrite are forced 0 combinationally.
  - All other outputs take their FETCH values.
  - Reset mid-instruction abandons it with no partial write.
- Outputs are Moore, decoded from state. The only exception is pcen's branch&zero term.
- ALU codes:
  - AND 00000, OR 00001, ADD 00010, SUB 10010, SLT 10011
  - XORI 00100, LUI 00101, SRLV 00110, LI 00111, BGTZ 01000
- ALU decoder, aluop 2 bits:
  - 00 -> ADD; 01 -> SUB
  - 10 -> by funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 000110 SRLV; any other funct -> ADD
  - 11 -> by op: XORI, LUI, LI, BGTZ
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, BGTZ 000111, ADDI 001000, XORI 001110, LUI 001111, LI 110000, J 000010.
- States and transitions (state code in brackets):
  - FETCH[0]: iord=0, alusrca=0, alusrcb=01, ADD, pcsrc=00, irwrite=1, pcwrite=1 -> DECODE.
  - DECODE[1]: alusrca=0, alusrcb=11, ADD (branch target into ALUOut). Next state by op:
    - LW/SW -> MEMADR
    - R -> EXECUTE
    - BEQ -> BEQEX
    - BGTZ -> BGTZEX
    - ADDI -> ADDIEX
    - XORI/LUI/LI -> IMMEX
    - J -> JUMP
    - any other op -> FETCH (treated as NOP)
  - MEMADR[2]: alusrca=1, alusrcb=10, ADD; LW -> MEMRD, SW -> MEMWR.
  - MEMRD[3]: iord=1 -> MEMWB.
  - MEMWB[4]: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
  - MEMWR[5]: iord=1, memwrite=1 -> FETCH.
  - EXECUTE[6]: alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
  - ALUWB[7]: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
  - BEQEX[8]: alusrca=1, alusrcb=00, SUB, pcsrc=01, branch=1 -> FETCH.
  - BGTZEX[9]: alusrca=1, alusrcb=00, BGTZ code, pcsrc=01, branch=1 -> FETCH.
    - The ALU returns 0 when A>0 signed, so zero=1 means taken.
    - A=0 or A negative: not taken.
  - ADDIEX[10]: alusrca=1, alusrcb=10, ADD -> IMMWB.
  - IMMEX[11]: alusrca=1, alusrcb=10, aluop=11 -> IMMWB.
  - IMMWB[12]: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
  - JUMP[13]: pcsrc=10, pcwrite=1 -> FETCH.
  - Codes 14/15 are illegal -> FETCH, all enables 0.
- Cycle counts per instruction:
  - LW 5; SW, R, ADDI/XORI/LUI/LI 4; BEQ, BGTZ, J 3
- Outputs not listed for a state default to 0, with alucontrol=ADD.

Decomposition:
- Package mc_pkg holds:
  - the state enum (4-bit, codes above)
  - opcode and funct localparams
  - the alucontrol localparams
  - the aluop encoding
- Sub-module mc_aludec (combinational; aluop, op, funct -> alucontrol), instantiated once in mc_controller.

Test Plan:
- Reset: hold reset_n=0 two cycles with op=LW, then release. Required: state=0 and pcen=irwrite=0 while held; at the first cycle after release, irwrite=1, pcen=1, alucontrol=00010.
- LW: op=100011. Required: states 0,1,2,3,4,0; regwrite=1 only in state 4 with memtoreg=1; total 5 cycles.
- R-type SRLV: op=0, funct=000110. Required: EXECUTE shows alucontrol=00110 and alusrcb=00; ALUWB shows regdst=1, regwrite=1.
- BGTZ, two cases:
  - zero=1 in BGTZEX: alucontrol=01000 and pcen=1, pcsrc=01.
  - zero=0: pcen=0.
- XORI, LUI, LI (op 001110, 001111, 110000): IMMEX alucontrol=00100, 00101, 00111 respectively; then IMMWB with regdst=0, regwrite=1.
- Unknown op 111111 in DECODE -> FETCH with no enable asserted. Also assert reset_n=0 during MEMWR: memwrite=0 in that cycle and state=0 next.
